// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: unit-select codes, FSM states, width defaults.
// Latency: none (declarations only).
// Backpressure: not applicable.
package alu_pkg;

    localparam int IN_WIDTH_DEF  = 8;
    localparam int OUT_WIDTH_DEF = 16;

    // FUN[3:2] unit select codes
    localparam logic [1:0] SEL_ARITH = 2'b00;
    localparam logic [1:0] SEL_LOGIC = 2'b01;
    localparam logic [1:0] SEL_CMP   = 2'b10;
    localparam logic [1:0] SEL_SHIFT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_t;

    // One-hot unit enable vector indexed by the select code (bit SEL_x set)
    function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO with extra-MSB pointers; full/empty from pointer compare.
// Latency: a push is visible at the head (dout/empty) the cycle after the push edge.
// Backpressure: pushes while full are ignored; pops while empty are ignored.
module alu_req_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

    assign o_dout  = r_mem[r_rptr[AW-1:0]];
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_count = r_wptr - r_rptr;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue stage for the hierarchical ALU: queues requests, drives one unit, returns results in order.
// Latency: push edge n -> ISSUE cycle n+1 -> res_valid from cycle n+2+UNIT_LAT; one op per UNIT_LAT+2 cycles.
// Backpressure: req_ready = !full (registered pointers); res_ready low holds the result and stalls issue.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int in_width   = IN_WIDTH_DEF,
    parameter int out_width  = OUT_WIDTH_DEF,
    parameter int FIFO_DEPTH = 4,
    parameter int UNIT_LAT   = 1
) (
    input  logic                        clk,
    input  logic                        RST,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [in_width-1:0]         req_A,
    input  logic [in_width-1:0]         req_B,
    input  logic [3:0]                  req_FUN,
    output logic [in_width-1:0]         A,
    output logic [in_width-1:0]         B,
    output logic [1:0]                  ALU_FUN,
    output logic                        Arith_Enable,
    output logic                        Logic_Enable,
    output logic                        CMP_Enable,
    output logic                        SHIFT_Enable,
    input  logic [out_width-1:0]        Arith_OUT,
    input  logic [out_width-1:0]        Logic_OUT,
    input  logic [out_width-1:0]        CMP_OUT,
    input  logic [out_width-1:0]        SHIFT_OUT,
    input  logic                        Arith_Flag,
    input  logic                        Logic_Flag,
    input  logic                        CMP_Flag,
    input  logic                        SHIFT_Flag,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [out_width-1:0]        res_data,
    output logic                        res_flag,
    output logic [3:0]                  res_fun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int EW    = 4 + 2 * in_width;
    localparam int CNT_W = (UNIT_LAT > 1) ? $clog2(UNIT_LAT) : 1;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_rdy_en;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [EW-1:0]        w_fifo_din;
    logic [EW-1:0]        w_fifo_dout;
    logic [in_width-1:0]  r_A;
    logic [in_width-1:0]  r_B;
    logic [3:0]           r_fun;
    logic [CNT_W-1:0]     r_cnt;
    logic [out_width-1:0] r_res_data;
    logic                 r_res_flag;
    logic [3:0]           r_res_fun;
    logic [out_width-1:0] w_unit_out;
    logic                 w_unit_flag;
    logic [3:0]           w_en;

    // Entry layout {FUN, A, B}
    assign w_fifo_din = {req_FUN, req_A, req_B};
    assign w_push     = req_valid & req_ready;
    // Only the transition into ISSUE consumes the head
    assign w_pop      = (w_state_nxt == ST_ISSUE);

    alu_req_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst_n   (RST),
        .i_push  (w_push),
        .i_din   (w_fifo_din),
        .i_pop   (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (fifo_count)
    );

    // Hold req_ready low through reset and until the first clock after release
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) r_rdy_en <= 1'b0;
        else      r_rdy_en <= 1'b1;
    end

    // Full comes from registered pointers, so a pop in a full cycle does not open ready
    assign req_ready = r_rdy_en & ~w_full;

    // FSM state register
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty) w_state_nxt = ST_ISSUE;
            ST_ISSUE: w_state_nxt = ST_WAIT;
            ST_WAIT:  if (r_cnt == '0) w_state_nxt = ST_RESP;
            ST_RESP:  if (res_ready) w_state_nxt = w_empty ? ST_IDLE : ST_ISSUE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Latch operands on pop, count unit latency, capture the selected unit's result
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_A        <= '0;
            r_B        <= '0;
            r_fun      <= '0;
            r_cnt      <= '0;
            r_res_data <= '0;
            r_res_flag <= 1'b0;
            r_res_fun  <= '0;
        end else begin
            if (w_pop) begin
                r_fun <= w_fifo_dout[EW-1 -: 4];
                r_A   <= w_fifo_dout[2*in_width-1 -: in_width];
                r_B   <= w_fifo_dout[in_width-1:0];
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= CNT_W'(UNIT_LAT - 1);
            end else if (r_state == ST_WAIT) begin
                if (r_cnt == '0) begin
                    r_res_data <= w_unit_out;
                    r_res_flag <= w_unit_flag;
                    r_res_fun  <= r_fun;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    // Result mux selected by the in-flight unit code
    always_comb begin
        w_unit_out  = Arith_OUT;
        w_unit_flag = Arith_Flag;
        case (r_fun[3:2])
            SEL_LOGIC: begin
                w_unit_out  = Logic_OUT;
                w_unit_flag = Logic_Flag;
            end
            SEL_CMP: begin
                w_unit_out  = CMP_OUT;
                w_unit_flag = CMP_Flag;
            end
            SEL_SHIFT: begin
                w_unit_out  = SHIFT_OUT;
                w_unit_flag = SHIFT_Flag;
            end
            default: begin
                w_unit_out  = Arith_OUT;
                w_unit_flag = Arith_Flag;
            end
        endcase
    end

    // FSM outputs: one enable during ISSUE/WAIT, result valid only in RESP
    always_comb begin
        w_en      = 4'b0000;
        res_valid = 1'b0;
        case (r_state)
            ST_ISSUE, ST_WAIT: w_en      = sel_onehot(r_fun[3:2]);
            ST_RESP:           res_valid = 1'b1;
            default: begin
                w_en      = 4'b0000;
                res_valid = 1'b0;
            end
        endcase
    end

    assign Arith_Enable = w_en[SEL_ARITH];
    assign Logic_Enable = w_en[SEL_LOGIC];
    assign CMP_Enable   = w_en[SEL_CMP];
    assign SHIFT_Enable = w_en[SEL_SHIFT];

    assign A        = r_A;
    assign B        = r_B;
    assign ALU_FUN  = r_fun[1:0];
    assign res_data = r_res_data;
    assign res_flag = r_res_flag;
    assign res_fun  = r_res_fun;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: unit models, queue scoreboard, directed and random traffic.
// Latency: checks the n+3 result timing and 3-cycle issue spacing for UNIT_LAT=1.
// Backpressure: exercises res_ready stalls, full FIFO and the full+pop edge.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_A, req_B;
    logic [3:0]  req_FUN;
    logic [7:0]  A, B;
    logic [1:0]  ALU_FUN;
    logic        Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable;
    logic [15:0] Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT;
    logic        Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_flag;
    logic [3:0]  res_fun;
    logic [2:0]  fifo_count;

    alu_issue_ctrl #(
        .in_width (8), .out_width (16), .FIFO_DEPTH (4), .UNIT_LAT (1)
    ) dut (
        .clk (clk), .RST (RST),
        .req_valid (req_valid), .req_ready (req_ready),
        .req_A (req_A), .req_B (req_B), .req_FUN (req_FUN),
        .A (A), .B (B), .ALU_FUN (ALU_FUN),
        .Arith_Enable (Arith_Enable), .Logic_Enable (Logic_Enable),
        .CMP_Enable (CMP_Enable), .SHIFT_Enable (SHIFT_Enable),
        .Arith_OUT (Arith_OUT), .Logic_OUT (Logic_OUT),
        .CMP_OUT (CMP_OUT), .SHIFT_OUT (SHIFT_OUT),
        .Arith_Flag (Arith_Flag), .Logic_Flag (Logic_Flag),
        .CMP_Flag (CMP_Flag), .SHIFT_Flag (SHIFT_Flag),
        .res_valid (res_valid), .res_ready (res_ready),
        .res_data (res_data), .res_flag (res_flag), .res_fun (res_fun),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] fun;
    } op_t;

    op_t         exp_q [$];
    int          log_cyc [$];
    logic [15:0] log_dat [$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [3:0]  en_v;
    op_t         mon_op;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, expv, $time);
        end
    endtask

    // What each ALU unit computes for a given FUN and operands
    function automatic logic [15:0] unit_calc(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] r;
        ea = {8'd0, a};
        eb = {8'd0, b};
        r  = 16'd0;
        case (f)
            4'b0000: r = ea + eb;
            4'b0001: r = ea - eb;
            4'b0010: r = ea * eb;
            4'b0011: r = (b == 8'd0) ? 16'hFFFF : ea / eb;
            4'b0100: r = ea & eb;
            4'b0101: r = ea | eb;
            4'b0110: r = ~(ea & eb);
            4'b0111: r = ~(ea | eb);
            4'b1000: r = (a == b) ? 16'd1 : 16'd0;
            4'b1001: r = (a > b)  ? 16'd1 : 16'd0;
            4'b1010: r = (a < b)  ? 16'd1 : 16'd0;
            4'b1011: r = (a != b) ? 16'd1 : 16'd0;
            4'b1100: r = ea >> 1;
            4'b1101: r = ea << 1;
            4'b1110: r = eb >> 1;
            default: r = eb << 1;
        endcase
        return r;
    endfunction

    // Unit models: one-cycle registered result, flag set when enabled last cycle
    always @(posedge clk or negedge RST) begin
        if (!RST) begin
            Arith_OUT <= 16'd0; Logic_OUT <= 16'd0; CMP_OUT <= 16'd0; SHIFT_OUT <= 16'd0;
            Arith_Flag <= 1'b0; Logic_Flag <= 1'b0; CMP_Flag <= 1'b0; SHIFT_Flag <= 1'b0;
        end else begin
            Arith_OUT  <= Arith_Enable ? unit_calc({2'b00, ALU_FUN}, A, B) : 16'd0;
            Logic_OUT  <= Logic_Enable ? unit_calc({2'b01, ALU_FUN}, A, B) : 16'd0;
            CMP_OUT    <= CMP_Enable   ? unit_calc({2'b10, ALU_FUN}, A, B) : 16'd0;
            SHIFT_OUT  <= SHIFT_Enable ? unit_calc({2'b11, ALU_FUN}, A, B) : 16'd0;
            Arith_Flag <= Arith_Enable;
            Logic_Flag <= Logic_Enable;
            CMP_Flag   <= CMP_Enable;
            SHIFT_Flag <= SHIFT_Enable;
        end
    end

    // Scoreboard: in-order queue of accepted requests; the head is the op in flight
    always @(negedge clk) begin
        if (RST) begin
            en_v = {Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable};
            check_val("en_onehot", 32'($countones(en_v) <= 1), 32'd1);
            if (en_v != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check_val("en_without_op", 32'(en_v), 32'd0);
                end else begin
                    check_val("en_sel", 32'(en_v), 32'(4'b1000 >> exp_q[0].fun[3:2]));
                    check_val("alu_fun", 32'(ALU_FUN), 32'(exp_q[0].fun[1:0]));
                    check_val("op_A", 32'(A), 32'(exp_q[0].a));
                    check_val("op_B", 32'(B), 32'(exp_q[0].b));
                end
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("res_unexpected", 32'(res_valid), 32'd0);
                end else begin
                    mon_op = exp_q.pop_front();
                    check_val("res_data", 32'(res_data), 32'(unit_calc(mon_op.fun, mon_op.a, mon_op.b)));
                    check_val("res_flag", 32'(res_flag), 32'd1);
                    check_val("res_fun", 32'(res_fun), 32'(mon_op.fun));
                end
                log_cyc.push_back(cyc);
                log_dat.push_back(res_data);
            end
            if (req_valid && req_ready) exp_q.push_back('{req_A, req_B, req_FUN});
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the push edge
    task automatic push_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        bit ok;
        ok = 1'b0;
        req_A = a; req_B = b; req_FUN = f; req_valid = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (!ok) check_val("push_timeout", 32'd0, 32'd1);
    endtask

    // One op into an idle design with res_ready high; checks per-cycle timing
    task automatic run_single(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                              input logic [3:0] exp_en, input logic [15:0] exp_dat);
        push_op(a, b, f);
        @(negedge clk);  // cycle n
        check_val("s_cnt_n", 32'(fifo_count), 32'd1);
        check_val("s_en_n", 32'({Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}), 32'd0);
        @(negedge clk);  // cycle n+1 ISSUE
        check_val("s_en_issue", 32'({Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}), 32'(exp_en));
        check_val("s_alufun", 32'(ALU_FUN), 32'(f[1:0]));
        check_val("s_cnt_issue", 32'(fifo_count), 32'd0);
        @(negedge clk);  // cycle n+2 WAIT
        check_val("s_en_wait", 32'({Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}), 32'(exp_en));
        check_val("s_rv_wait", 32'(res_valid), 32'd0);
        @(negedge clk);  // cycle n+3 RESP
        check_val("s_rv_resp", 32'(res_valid), 32'd1);
        check_val("s_data", 32'(res_data), 32'(exp_dat));
        check_val("s_flag", 32'(res_flag), 32'd1);
        check_val("s_fun", 32'(res_fun), 32'(f));
        check_val("s_en_resp", 32'({Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain(input string tag);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 500 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !res_valid) done = 1'b1;
        end
        check_val(tag, 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    bit          rnd_done;
    logic [15:0] t4_exp [4];
    logic [3:0]  t3_fun [4];
    logic [3:0]  t3_en  [4];
    logic [15:0] t3_dat [4];

    initial begin
        t4_exp = '{16'd63, 16'd14, 16'hFFFD, 16'hFFC8};
        t3_fun = '{4'b0001, 4'b0110, 4'b1011, 4'b1111};
        t3_en  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        t3_dat = '{16'd13, 16'hFFFB, 16'd1, 16'd14};
        RST = 1'b0; req_valid = 1'b0; req_A = '0; req_B = '0; req_FUN = '0; res_ready = 1'b1;

        // Reset state
        #3;
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_valid", 32'(res_valid), 32'd0);
        check_val("rst_count", 32'(fifo_count), 32'd0);
        check_val("rst_data", 32'(res_data), 32'd0);
        check_val("rst_en", 32'({Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}), 32'd0);
        @(posedge clk); #2; RST = 1'b1;
        @(negedge clk); @(negedge clk);
        check_val("post_rst_ready", 32'(req_ready), 32'd1);
        check_val("post_rst_count", 32'(fifo_count), 32'd0);
        @(posedge clk); #1;

        // Reset asserted mid-WAIT discards the in-flight op and the queue
        push_op(8'd3, 8'd4, 4'b0000);
        push_op(8'd9, 8'd2, 4'b1101);
        @(negedge clk);  // ISSUE of first
        @(negedge clk);  // WAIT of first
        check_val("rw_pre_en", 32'(Arith_Enable), 32'd1);
        check_val("rw_pre_cnt", 32'(fifo_count), 32'd1);
        #2; RST = 1'b0; exp_q.delete();
        #1;
        check_val("rw_en", 32'({Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}), 32'd0);
        check_val("rw_valid", 32'(res_valid), 32'd0);
        check_val("rw_count", 32'(fifo_count), 32'd0);
        check_val("rw_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #2; RST = 1'b1;
        @(negedge clk); @(negedge clk);
        check_val("rw_post_ready", 32'(req_ready), 32'd1);
        for (int k = 0; k < 6; k++) begin
            check_val("rw_no_stale", 32'({res_valid, Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable}), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;

        // Single op, Logic AND
        run_single(8'd15, 8'd30, 4'b0100, 4'b0100, 16'd14);

        // Decode sweep
        for (int i = 0; i < 4; i++) run_single(8'd20, 8'd7, t3_fun[i], t3_en[i], t3_dat[i]);

        // Ordering and spacing with four back-to-back pushes
        log_cyc.delete(); log_dat.delete();
        push_op(8'd50, 8'd15, 4'b0101);
        push_op(8'd15, 8'd30, 4'b0100);
        push_op(8'd50, 8'd15, 4'b0110);
        push_op(8'd50, 8'd5,  4'b0111);
        wait_drain("ord_drain");
        check_val("ord_count", 32'(log_dat.size()), 32'd4);
        if (log_dat.size() == 4) begin
            for (int i = 0; i < 4; i++) check_val("ord_data", 32'(log_dat[i]), 32'(t4_exp[i]));
            for (int i = 1; i < 4; i++) check_val("ord_spacing", 32'(log_cyc[i] - log_cyc[i-1]), 32'd3);
        end

        // Back-pressure: six pushes with res_ready low
        log_cyc.delete(); log_dat.delete();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_op(8'(10 + i), 8'(3 * i + 1), 4'(i * 3));
        req_A = 8'd77; req_B = 8'd11; req_FUN = 4'b1001; req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("bp_ready", 32'(req_ready), 32'd0);
            check_val("bp_count", 32'(fifo_count), 32'd4);
            check_val("bp_valid", 32'(res_valid), 32'd1);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(negedge clk);  // pop happens at the next edge while full
        check_val("fp_ready_full", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_val("fp_no_push", 32'(fifo_count), 32'd3);
        check_val("fp_ready_next", 32'(req_ready), 32'd1);
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk);
        check_val("fp_pushed", 32'(fifo_count), 32'd4);
        @(posedge clk); #1;
        wait_drain("bp_drain");
        check_val("bp_results", 32'(log_dat.size()), 32'd6);

        // Random traffic with random result back-pressure
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 80; i++) begin
                    push_op(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    res_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        res_ready = 1'b1;
        wait_drain("rnd_drain");
        check_val("final_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
